// File: rtl/frame_config_writer.sv
// frame_config_writer: streams valid/ready words into one fabric column's
// FrameData/FrameStrobe configuration port. SET_ADDR selects the first frame,
// and each following data word writes the next frame.
// Optional feature macro: FRAME_WRITER_CHECKSUM_EN adds a 16-bit running
// checksum of the accepted data words.
module frame_config_writer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int StrobeCycles    = 1
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_cmd,
  input  logic [FrameBitsPerRow-1:0] s_data,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  output logic                       col_done
`ifdef FRAME_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]                checksum
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam int IW = 5;
  localparam int CW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(MaxFramesPerCol - 1);
  localparam logic [IW:0]    NUM_FRM  = (IW + 1)'(MaxFramesPerCol);
  localparam logic [CW-1:0]  CNT_LAST = CW'(StrobeCycles - 1);
  localparam logic [MaxFramesPerCol-1:0] ONE = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

  localparam logic [1:0] OP_SET_ADDR = 2'b00;
  localparam logic [1:0] OP_CLEAR    = 2'b01;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          addr_valid;
  logic [CW-1:0] cnt;
  logic          hs;
  logic [1:0]    opcode;

  assign s_ready  = resetn & (state == IDLE);
  assign hs       = s_valid & s_ready;
  assign opcode   = s_data[31:30];
  assign busy     = (state != IDLE);
  assign col_done = (state == HOLD) && (idx == LAST_IDX);

  // Command decode, frame write sequencing and strobe generation.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      FrameData   <= '0;
      FrameStrobe <= '0;
      err         <= 1'b0;
      idx         <= '0;
      addr_valid  <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            if (s_cmd) begin
              case (opcode)
                OP_SET_ADDR: begin
                  idx <= s_data[IW-1:0];
                  if ({1'b0, s_data[IW-1:0]} >= NUM_FRM) begin
                    err        <= 1'b1;
                    addr_valid <= 1'b0;
                  end else begin
                    addr_valid <= 1'b1;
                  end
                end
                OP_CLEAR: begin
                  err        <= 1'b0;
                  addr_valid <= 1'b0;
                end
                default: err <= 1'b1;
              endcase
            end else if (addr_valid) begin
              FrameData <= s_data;
              state     <= SETUP;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SETUP: begin
          FrameStrobe <= ONE << idx;
          cnt         <= '0;
          state       <= STROBE;
        end
        STROBE: begin
          if (cnt == CNT_LAST) begin
            FrameStrobe <= '0;
            state       <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          if (idx == LAST_IDX) begin
            idx        <= '0;
            addr_valid <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FRAME_WRITER_CHECKSUM_EN
  // Running sum of both halves of every accepted data word; CLEAR zeroes it.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      checksum <= '0;
    end else if (hs) begin
      if (s_cmd && (opcode == OP_CLEAR)) begin
        checksum <= '0;
      end else if (!s_cmd && addr_valid) begin
        checksum <= checksum + s_data[15:0] + s_data[31:16];
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed bench for frame_config_writer with a strobe scoreboard.
module tb_frame_config_writer;

  localparam int FB = 32;
  localparam int NF = 20;

  logic          UserCLK = 1'b0;
  logic          resetn  = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_cmd   = 1'b0;
  logic [FB-1:0] s_data  = '0;
  logic [FB-1:0] FrameData;
  logic [NF-1:0] FrameStrobe;
  logic          busy;
  logic          err;
  logic          col_done;
`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  frame_config_writer #(
    .FrameBitsPerRow(FB),
    .MaxFramesPerCol(NF),
    .StrobeCycles(1)
  ) dut (
    .UserCLK(UserCLK),
    .resetn(resetn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_cmd(s_cmd),
    .s_data(s_data),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .err(err),
    .col_done(col_done)
`ifdef FRAME_WRITER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 UserCLK = ~UserCLK;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int cyc = 0;
  always @(posedge UserCLK) cyc++;

  typedef struct {
    logic [NF-1:0] strobe;
    logic [FB-1:0] data;
  } exp_t;
  exp_t sbq[$];

  // reference model state
  int          m_idx = 0;
  bit          m_av  = 1'b0;
  bit          m_err = 1'b0;
  logic [15:0] m_sum = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: one-hot check every cycle, scoreboard pop on each new strobe.
  logic [NF-1:0] prev_strobe = '0;
  always @(negedge UserCLK) begin
    if (resetn) begin
      chk("strobe_onehot", 64'($countones(FrameStrobe) <= 1), 64'd1);
      if (FrameStrobe != '0 && prev_strobe == '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", 64'(FrameStrobe), 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_strobe", 64'(FrameStrobe), 64'(e.strobe));
          chk("sb_data", 64'(FrameData), 64'(e.data));
        end
      end
      prev_strobe = FrameStrobe;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge UserCLK);
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input bit cmd, input logic [FB-1:0] data, input bit keep, output int hs);
    bit done;
    bit acc;
    logic [NF-1:0] msk;
    done = 1'b0;
    acc  = 1'b0;
    hs   = -1;
    s_valid = 1'b1;
    s_cmd   = cmd;
    s_data  = data;
    for (int i = 0; i < 50 && !done; i++) begin
      if (s_ready) begin
        @(posedge UserCLK);
        #1;
        hs   = cyc;
        done = 1'b1;
      end else begin
        @(negedge UserCLK);
      end
    end
    chk("handshake", 64'(done), 64'd1);
    if (!done) begin
      s_valid = 1'b0;
      return;
    end
    if (cmd) begin
      case (data[31:30])
        2'b00: begin
          m_idx = int'(data[4:0]);
          if (m_idx >= NF) begin
            m_err = 1'b1;
            m_av  = 1'b0;
          end else begin
            m_av = 1'b1;
          end
        end
        2'b01: begin
          m_err = 1'b0;
          m_av  = 1'b0;
          m_sum = '0;
        end
        default: m_err = 1'b1;
      endcase
    end else if (m_av) begin
      msk = '0;
      msk[m_idx] = 1'b1;
      sbq.push_back('{strobe: msk, data: data});
      m_sum = m_sum + data[15:0] + data[31:16];
      acc = 1'b1;
      if (m_idx == NF - 1) begin
        m_idx = 0;
        m_av  = 1'b0;
      end else begin
        m_idx++;
      end
    end else begin
      m_err = 1'b1;
    end
    @(negedge UserCLK);
    if (!keep) s_valid = 1'b0;
    chk("err", 64'(err), 64'(m_err));
    if (acc) begin
      chk("setup_data", 64'(FrameData), 64'(data));
      chk("setup_busy", 64'(busy), 64'd1);
      chk("setup_nostrobe", 64'(FrameStrobe), 64'd0);
    end else begin
      chk("idle_ready", 64'(s_ready), 64'd1);
    end
`ifdef FRAME_WRITER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(m_sum));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int h[4];

    // reset state
    repeat (3) @(negedge UserCLK);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_strobe", 64'(FrameStrobe), 64'd0);
    chk("rst_data", 64'(FrameData), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_done", 64'(col_done), 64'd0);
    resetn = 1'b1;
    @(negedge UserCLK);
    chk("post_rst_ready", 64'(s_ready), 64'd1);

    // single write, latency
    send(1'b1, 32'h0000_0003, 1'b0, hs);
    send(1'b0, 32'hA5A5_0F0F, 1'b0, hs);
    @(negedge UserCLK);
    chk("t2_strobe", 64'(FrameStrobe), 64'h8);
    @(negedge UserCLK);
    chk("t3_strobe", 64'(FrameStrobe), 64'h0);
    chk("t3_ready", 64'(s_ready), 64'd0);
    chk("t3_done", 64'(col_done), 64'd0);
    @(negedge UserCLK);
    chk("t4_ready", 64'(s_ready), 64'd1);
    chk("t4_data_hold", 64'(FrameData), 64'hA5A5_0F0F);

    // end of column, col_done, dropped word afterwards
    send(1'b1, 32'h0000_0012, 1'b0, hs);
    send(1'b0, 32'h1111_2222, 1'b0, hs);
    idle(2);
    chk("d0_done", 64'(col_done), 64'd0);
    idle(1);
    send(1'b0, 32'h3333_4444, 1'b0, hs);
    idle(2);
    chk("d1_done", 64'(col_done), 64'd1);
    idle(1);
    chk("d1_done_end", 64'(col_done), 64'd0);
    send(1'b0, 32'h5555_6666, 1'b0, hs);
    idle(5);

    // address range, CLEAR, reserved opcodes, err does not block writes
    send(1'b1, 32'h0000_0014, 1'b0, hs);
    send(1'b1, 32'h4000_0000, 1'b0, hs);
    send(1'b0, 32'h7777_8888, 1'b0, hs);
    send(1'b1, 32'h4000_0000, 1'b0, hs);
    send(1'b1, 32'hC000_0000, 1'b0, hs);
    send(1'b1, 32'h4000_0000, 1'b0, hs);
    send(1'b1, 32'h8000_0000, 1'b0, hs);
    send(1'b1, 32'h0000_0007, 1'b0, hs);
    send(1'b0, 32'h0BAD_F00D, 1'b0, hs);
    idle(4);

    // back-to-back with s_valid held high
    send(1'b1, 32'h4000_0000, 1'b0, hs);
    send(1'b1, 32'h0000_0000, 1'b0, hs);
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 32'hC0DE_0000 + 32'(i), (i < 3), h[i]);
    end
    for (int i = 1; i < 4; i++) begin
      chk("b2b_spacing", 64'(h[i] - h[i-1]), 64'd4);
    end
    idle(4);

    // asynchronous reset during STROBE
    send(1'b1, 32'h0000_0005, 1'b0, hs);
    send(1'b0, 32'h5555_AAAA, 1'b0, hs);
    @(negedge UserCLK);
    chk("pre_rst_strobe", 64'(FrameStrobe), 64'h20);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_strobe", 64'(FrameStrobe), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(s_ready), 64'd0);
    m_idx = 0;
    m_av  = 1'b0;
    m_err = 1'b0;
    m_sum = '0;
    idle(2);
    resetn = 1'b1;
    @(negedge UserCLK);
    chk("arst_data", 64'(FrameData), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    send(1'b0, 32'h1234_5678, 1'b0, hs);
    idle(4);

`ifdef FRAME_WRITER_CHECKSUM_EN
    send(1'b1, 32'h4000_0000, 1'b0, hs);
    send(1'b1, 32'h0000_0000, 1'b0, hs);
    send(1'b0, 32'h0001_0002, 1'b0, hs);
    chk("cks_first", 64'(checksum), 64'h0003);
    idle(3);
    send(1'b0, 32'hFFFF_FFFF, 1'b0, hs);
    chk("cks_second", 64'(checksum), 64'h0001);
    idle(3);
    send(1'b1, 32'h4000_0000, 1'b0, hs);
    chk("cks_clear", 64'(checksum), 64'h0000);
`endif

    idle(8);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
